// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port round-robin RAM arbiter: port identifiers,
// the read-pipeline tag and the fixed read latency seen by clients.
package ram_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     vld;
        logic     rd;
        port_id_t id;
    } stage_tag_t;

    // Accepting edge to resp_valid: one edge for the RAM access, one for the response register.
    localparam int RD_LATENCY = 2;

    localparam stage_tag_t TAG_IDLE = '{vld: 1'b0, rd: 1'b0, id: PORT_A};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie
// and flips to the losing side after every grant.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_id_t r_ptr;

    // NOTE: every output of an always_comb gets a default first so no latch can be inferred.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_ptr == PORT_B) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PORT_A;
        end else if (gnt[0]) begin
            r_ptr <= PORT_B;
        end else if (gnt[1]) begin
            r_ptr <= PORT_A;
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one single-port registered-read RAM between two valid/ready clients:
// one command per cycle, reads return to their owner two edges after acceptance.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_resp_valid,
    output logic [DATA_WIDTH-1:0] a_resp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_resp_valid,
    output logic [DATA_WIDTH-1:0] b_resp_rdata,

    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic [1:0]            w_gnt;
    logic                  w_acc;
    logic                  w_we;
    port_id_t              w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    stage_tag_t            r_s1;
    stage_tag_t            r_s2;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_req_valid, a_req_valid}),
        .gnt (w_gnt)
    );

    // Nothing is accepted while reset is high, so no command survives into the pipeline.
    assign a_req_ready = w_gnt[0] & ~rst;
    assign b_req_ready = w_gnt[1] & ~rst;
    assign w_acc       = a_req_ready | b_req_ready;

    assign w_id    = w_gnt[1] ? PORT_B : PORT_A;
    assign w_we    = w_gnt[1] ? b_req_we    : a_req_we;
    assign w_addr  = w_gnt[1] ? b_req_addr  : a_req_addr;
    assign w_wdata = w_gnt[1] ? b_req_wdata : a_req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            r_s1      <= TAG_IDLE;
            r_s2      <= TAG_IDLE;
        end else begin
            r_s2 <= r_s1;
            if (w_acc) begin
                ram_cs    <= 1'b1;
                ram_we    <= w_we;
                ram_oe    <= ~w_we;
                ram_addr  <= w_addr;
                ram_wdata <= w_we ? w_wdata : '0;
                r_s1      <= '{vld: 1'b1, rd: ~w_we, id: w_id};
            end else begin
                // Address and write data hold on idle cycles; only the strobes drop.
                ram_cs <= 1'b0;
                ram_we <= 1'b0;
                ram_oe <= 1'b0;
                r_s1   <= TAG_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            a_resp_rdata <= '0;
            b_resp_rdata <= '0;
        end else begin
            a_resp_valid <= r_s2.vld & r_s2.rd & (r_s2.id == PORT_A);
            b_resp_valid <= r_s2.vld & r_s2.rd & (r_s2.id == PORT_B);
            if (r_s2.vld && r_s2.rd && r_s2.id == PORT_A) begin
                a_resp_rdata <= ram_rdata;
            end
            if (r_s2.vld && r_s2.rd && r_s2.id == PORT_B) begin
                b_resp_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Self-checking bench: behavioural registered-read RAM, a shadow memory updated in
// grant order, and per-port queues of expected read data checked on resp_valid.
module tb_ram_sp_arbiter;
    import ram_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_mem;

    logic       a_req_valid, a_req_ready, a_req_we;
    logic [7:0] a_req_addr, a_req_wdata;
    logic       a_resp_valid;
    logic [7:0] a_resp_rdata;
    logic       b_req_valid, b_req_ready, b_req_we;
    logic [7:0] b_req_addr, b_req_wdata;
    logic       b_resp_valid;
    logic [7:0] b_resp_rdata;
    logic       ram_cs, ram_we, ram_oe;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       a_q[$];
    exp_t       b_q[$];
    logic [7:0] ram_mem [256];
    logic [7:0] shadow  [256];

    ram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_req_we     (a_req_we),
        .a_req_addr   (a_req_addr),
        .a_req_wdata  (a_req_wdata),
        .a_resp_valid (a_resp_valid),
        .a_resp_rdata (a_resp_rdata),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_req_we     (b_req_we),
        .b_req_addr   (b_req_addr),
        .b_req_wdata  (b_req_wdata),
        .b_resp_valid (b_resp_valid),
        .b_resp_rdata (b_resp_rdata),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_oe       (ram_oe),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Behavioural single-port RAM with registered read.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'hA5;
        end else if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else if (ram_oe) ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Monitor: protocol checks, scoreboard push on acceptance, pop on response.
    always @(negedge clk) begin
        exp_t e;
        if (init_mem) begin
            for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hA5;
        end
        check("rdy_onehot", {31'd0, a_req_ready & b_req_ready}, 0);
        check("a_rdy_wo_vld", {31'd0, a_req_ready & ~a_req_valid}, 0);
        check("b_rdy_wo_vld", {31'd0, b_req_ready & ~b_req_valid}, 0);
        if (a_resp_valid) begin
            if (a_q.size() == 0) check("a_resp_unexpected", 1, 0);
            else begin
                e = a_q.pop_front();
                check("a_rdata", {24'd0, a_resp_rdata}, {24'd0, e.data});
                check("a_latency", cyc - e.cyc, RD_LATENCY);
            end
        end
        if (b_resp_valid) begin
            if (b_q.size() == 0) check("b_resp_unexpected", 1, 0);
            else begin
                e = b_q.pop_front();
                check("b_rdata", {24'd0, b_resp_rdata}, {24'd0, e.data});
                check("b_latency", cyc - e.cyc, RD_LATENCY);
            end
        end
        if (rst) begin
            a_q.delete();
            b_q.delete();
        end else if (a_req_valid && a_req_ready) begin
            if (a_req_we) shadow[a_req_addr] = a_req_wdata;
            else a_q.push_back('{data: shadow[a_req_addr], cyc: cyc + 1});
        end else if (b_req_valid && b_req_ready) begin
            if (b_req_we) shadow[b_req_addr] = b_req_wdata;
            else b_q.push_back('{data: shadow[b_req_addr], cyc: cyc + 1});
        end
    end

    task automatic set_a(input logic v, input logic we, input logic [7:0] addr, input logic [7:0] d);
        a_req_valid = v;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [7:0] addr, input logic [7:0] d);
        b_req_valid = v;
        b_req_we    = we;
        b_req_addr  = addr;
        b_req_wdata = d;
    endtask

    task automatic idle_all();
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle_all();
        step();
        rst = 1'b0;
    endtask

    // Both ports hold three reads each; grants must alternate starting at first_b.
    task automatic run_contention(input logic first_b);
        int  ai = 0;
        int  bi = 0;
        logic exp_b;
        for (int i = 0; i < 6; i++) begin
            step();
            set_a(ai < 3, 1'b0, 8'(ai), 8'h00);
            set_b(bi < 3, 1'b0, 8'(3 + bi), 8'h00);
            @(negedge clk);
            exp_b = first_b ^ i[0];
            check("cont_a_rdy", {31'd0, a_req_ready}, {31'd0, ~exp_b});
            check("cont_b_rdy", {31'd0, b_req_ready}, {31'd0, exp_b});
            if (a_req_ready) ai++;
            if (b_req_ready) bi++;
        end
        step();
        idle_all();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        init_mem = 1'b1;
        idle_all();
        set_a(1'b1, 1'b1, 8'h10, 8'h5A);
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        @(negedge clk);
        check("rst_a_rdy", {31'd0, a_req_ready}, 0);
        check("rst_cs", {31'd0, ram_cs}, 0);
        check("rst_we", {31'd0, ram_we}, 0);
        check("rst_oe", {31'd0, ram_oe}, 0);
        check("rst_addr", {24'd0, ram_addr}, 0);
        check("rst_wdata", {24'd0, ram_wdata}, 0);
        check("rst_a_resp", {23'd0, a_resp_valid, a_resp_rdata}, 0);
        check("rst_b_resp", {23'd0, b_resp_valid, b_resp_rdata}, 0);

        // First write from A, accepted in the release cycle.
        step();
        rst = 1'b0;
        @(negedge clk);
        check("wr_a_rdy", {31'd0, a_req_ready}, 1);
        check("wr_b_rdy", {31'd0, b_req_ready}, 0);
        step();
        idle_all();
        @(negedge clk);
        check("wr_cs", {31'd0, ram_cs}, 1);
        check("wr_we", {31'd0, ram_we}, 1);
        check("wr_oe", {31'd0, ram_oe}, 0);
        check("wr_addr", {24'd0, ram_addr}, 32'h10);
        check("wr_wdata", {24'd0, ram_wdata}, 32'h5A);

        // Single read of the same address.
        step();
        set_a(1'b1, 1'b0, 8'h10, 8'hFF);
        @(negedge clk);
        check("rd_a_rdy", {31'd0, a_req_ready}, 1);
        step();
        idle_all();
        @(negedge clk);
        check("rd_cs", {31'd0, ram_cs}, 1);
        check("rd_oe", {31'd0, ram_oe}, 1);
        check("rd_we", {31'd0, ram_we}, 0);
        check("rd_wdata", {24'd0, ram_wdata}, 0);
        step();
        @(negedge clk);
        check("idle_cs", {31'd0, ram_cs}, 0);
        check("idle_addr_hold", {24'd0, ram_addr}, 32'h10);
        repeat (3) step();
        @(negedge clk);
        check("a_rdata_hold", {24'd0, a_resp_rdata}, 32'h5A);

        // Contention from reset (A first), then with the pointer parked on B.
        do_reset();
        run_contention(1'b0);
        step();
        set_a(1'b1, 1'b0, 8'h06, 8'h00);
        @(negedge clk);
        check("solo_a_rdy", {31'd0, a_req_ready}, 1);
        step();
        idle_all();
        run_contention(1'b1);
        repeat (3) step();

        // Back-to-back write then read from B, interleaved with A reads.
        step();
        set_b(1'b1, 1'b1, 8'h20, 8'hC3);
        @(negedge clk);
        check("mix_b_wr_rdy", {31'd0, b_req_ready}, 1);
        step();
        set_b(1'b1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        check("mix_b_rd_rdy", {31'd0, b_req_ready}, 1);
        step();
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        set_a(1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("mix_a_rd_rdy", {31'd0, a_req_ready}, 1);
        step();
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        check("mix_b_rd2_rdy", {31'd0, b_req_ready}, 1);
        step();
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        set_a(1'b1, 1'b0, 8'h03, 8'h00);
        @(negedge clk);
        check("mix_a_rd2_rdy", {31'd0, a_req_ready}, 1);
        step();
        idle_all();
        repeat (4) step();
        @(negedge clk);
        check("mix_b_rdata_c3", {24'd0, b_resp_rdata}, 32'hC3);

        // Read accepted, then reset on the following edge: its response must never appear.
        step();
        set_a(1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("mid_a_rdy", {31'd0, a_req_ready}, 1);
        step();
        rst = 1'b1;
        idle_all();
        step();
        rst = 1'b0;
        set_a(1'b1, 1'b0, 8'h11, 8'h00);
        set_b(1'b1, 1'b0, 8'h12, 8'h00);
        @(negedge clk);
        check("mid_ptr_a_rdy", {31'd0, a_req_ready}, 1);
        check("mid_ptr_b_rdy", {31'd0, b_req_ready}, 0);
        step();
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("mid_b_rdy", {31'd0, b_req_ready}, 1);
        step();
        idle_all();

        // Idle gap, then a lone B request with the pointer on A.
        step();
        repeat (5) begin
            step();
            @(negedge clk);
            check("gap_cs", {31'd0, ram_cs}, 0);
        end
        step();
        set_b(1'b1, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        check("gap_b_rdy", {31'd0, b_req_ready}, 1);
        check("gap_a_rdy", {31'd0, a_req_ready}, 0);
        step();
        idle_all();
        @(negedge clk);
        check("gap_cs_on", {31'd0, ram_cs}, 1);
        check("gap_oe_on", {31'd0, ram_oe}, 1);
        check("gap_addr", {24'd0, ram_addr}, 32'h30);
        repeat (5) step();
        @(negedge clk);

        check("a_q_drained", a_q.size(), 0);
        check("b_q_drained", b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
Two-requester round-robin controller that shares one single-port synchronous RAM (cs/we/oe control, registered read) between ports A and B. Each port issues read/write commands over a valid/ready handshake. Read data returns on a per-port response strobe. The block sits between two client engines and the RAM tristate wrapper; RAM-side buses are split (wdata/rdata), and the tristate is resolved outside this block.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 8, RAM address width (depth 2**ADDR_WIDTH)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
a_req_valid  in  1  port A command valid
a_req_ready  out  1  port A command accepted this cycle
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  ADDR_WIDTH  port A address
a_req_wdata  in  DATA_WIDTH  port A write data
a_resp_valid  out  1  port A read data valid (one-cycle pulse)
a_resp_rdata  out  DATA_WIDTH  port A read data
b_*  same seven signals for port B
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable (high for reads)
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset (synchronous, rst=1 at an edge): ram_cs/ram_we/ram_oe=0; ram_addr, ram_wdata=0; a/b_resp_valid=0; a/b_resp_rdata=0; in-flight pipeline tags cleared; priority pointer = A.
- Reset mid-operation: all in-flight reads are dropped. No resp_valid may fire for a command accepted before reset.
- Arbitration (combinational, one grant per cycle): only A valid -> A; only B valid -> B; both valid -> port at priority pointer. x_req_ready = grant to x and !rst. Ready never asserts without valid.
- Pointer update: after any grant, pointer moves to the non-granted port; unchanged on idle cycles. Under continuous contention this yields strict alternation A,B,A,B...
- Handshake edge E0 (valid & ready): register ram_cs=1, ram_we=req_we, ram_oe=!req_we, ram_addr, ram_wdata (0 for reads), and stage-1 tag {read, port}.
- Idle cycle (no grant): ram_cs=ram_we=ram_oe=0 at next edge; addr/wdata hold their last values.
- E1: RAM performs write or captures read. Stage-1 tag moves to stage-2.
- E2: if stage-2 tag is a read, register ram_rdata into the owning port's resp_rdata and pulse its resp_valid for exactly one cycle. The other port's resp_valid=0. resp_rdata holds between pulses.
- Read latency: resp_valid is high in the cycle after E2, i.e. 2 clocks after the accepting edge. Throughput: one command per cycle, total, across both ports.
- Writes produce no response.
- Ordering: commands execute in grant order. A read issued the cycle after a write to the same address returns the new data; no forwarding is needed.
- Responses cannot be back-pressured; clients must always accept resp_valid.
- Commands held with valid=1 while ready=0 must be held stable by the client (standard valid/ready). The arbiter never drops or reorders them.

Decomposition:
- Package ram_arb_pkg: port_id_t enum {PORT_A, PORT_B}; struct for stage tag {logic vld; logic rd; port_id_t id}; localparam RD_LATENCY = 2.
- Sub-module rr_arb2: 2-way round-robin arbiter with ports clk, rst, req[1:0], gnt[1:0], holding the priority pointer.
- Top level: command register, 2-stage tag pipeline, response demux.

Test Plan:
- Reset check: rst=1 for 2 cycles -> all outputs 0. Release; A writes addr 0x10 data 0x5A -> a_req_ready=1 same cycle; next cycle ram_cs=1, ram_we=1, ram_addr=0x10, ram_wdata=0x5A.
- Single read: A reads 0x10 after that write -> ram_oe=1 one cycle after accept; a_resp_valid pulses with a_resp_rdata=0x5A exactly 2 cycles after accept; b_resp_valid stays 0.
- Contention: A and B both hold valid for 6 cycles, addresses 0x00..0x05 -> grants alternate A,B,A,B,A,B starting with A after reset. Repeat with pointer at B -> B first.
- Back-to-back mixed: B writes 0x20=0xC3, then B reads 0x20 next cycle -> b_resp_rdata=0xC3. Interleaved A reads return their own data, each tagged to the correct port.
- Reset mid-flight: A read accepted, rst asserted on the following edge -> no a_resp_valid pulse ever appears. Pointer returns to A.
- Idle gaps: single B request after 5 idle cycles with no A traffic -> granted immediately regardless of pointer. ram_cs=0 on all idle cycles.
